// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the memory port controller
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_BYTES  = 2 ** DEF_ADDR_W;

  typedef enum logic {
    CLEAR,
    SERVE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered last-winner pointer
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
    if (advance && found) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(NREQ - 1);
    end else if (advance && found) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single memory port among requesters and sequences memory clear
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_start,
  output logic                     busy,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [7:0]               mem_msb_addr,
  output logic [7:0]               mem_lsb_addr,
  output logic [DATA_W-1:0]        mem_wval,
  output logic                     mem_wen,
  input  logic [DATA_W-1:0]        mem_rval
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [15:0]       maddr;
  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  win;
  logic              advance;
  logic              clear_go;
  logic              t1_v, t2_v;
  logic [IDX_W-1:0]  t1_i, t2_i;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .gnt     (arb_gnt),
    .idx     (win)
  );

  assign gnt          = arb_gnt;
  assign busy         = (state == CLEAR);
  assign mem_msb_addr = maddr[15:8];
  assign mem_lsb_addr = maddr[7:0];

  // A clear request pre-empts any grant in its cycle.
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    clear_go = 1'b0;
    case (state)
      CLEAR: if (cnt == '1) state_nx = SERVE;
      SERVE: begin
        if (clear_start) begin
          state_nx = CLEAR;
          clear_go = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
    endcase
  end

  // cnt rests at zero in SERVE (it rolls over on the last clear write), so the
  // pulse cycle can issue address 0 directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
      cnt      <= '0;
      maddr    <= '0;
      mem_wval <= '0;
      mem_wen  <= 1'b0;
      t1_v     <= 1'b0;
      t1_i     <= '0;
      t2_v     <= 1'b0;
      t2_i     <= '0;
    end else begin
      state <= state_nx;
      t1_v  <= (|arb_gnt) && !we[win];
      t1_i  <= win;
      t2_v  <= t1_v;
      t2_i  <= t1_i;
      if (state == CLEAR || clear_go) begin
        mem_wen  <= 1'b1;
        mem_wval <= '0;
        maddr    <= 16'(cnt);
        cnt      <= cnt + ADDR_W'(1);
      end else if (|arb_gnt) begin
        mem_wen  <= we[win];
        mem_wval <= wdata[win*DATA_W +: DATA_W];
        maddr    <= 16'(addr[win*ADDR_W +: ADDR_W]);
      end else begin
        mem_wen <= 1'b0;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (t2_v) rvalid[t2_i] = 1'b1;
  end

  assign rdata = t2_v ? mem_rval : '0;

endmodule
